// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocate at tail, out-of-order completion, in-order commit.
// Optional macro ROB_RESULT_BYPASS_EN forwards a same-cycle result onto the read ports.
module reorder_buffer #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned EXC_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  write_en,
  output logic                  can_write,
  output logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  write_reg_write_en,
  input  logic [4:0]            write_reg_write_addr,
  input  logic [EXC_WIDTH-1:0]  write_exception_type,
  input  logic                  write_is_delayslot,
  input  logic [31:0]           write_pc,
  input  logic                  result_en,
  input  logic [ADDR_WIDTH-1:0] result_addr,
  input  logic [31:0]           result_data,
  input  logic [EXC_WIDTH-1:0]  result_exception_type,
  input  logic                  commit_en,
  output logic                  can_commit,
  output logic                  commit_reg_write_en,
  output logic [4:0]            commit_reg_write_addr,
  output logic [31:0]           commit_reg_write_data,
  output logic [EXC_WIDTH-1:0]  commit_exception_type,
  output logic                  commit_is_delayslot,
  output logic [31:0]           commit_pc,
  input  logic [ADDR_WIDTH-1:0] read_addr_1,
  input  logic [ADDR_WIDTH-1:0] read_addr_2,
  output logic                  read_ready_1,
  output logic                  read_ready_2,
  output logic [31:0]           read_data_1,
  output logic [31:0]           read_data_2
);

  localparam int Depth = int'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] FullCount = (ADDR_WIDTH + 1)'(Depth);

  logic                  valid_q    [Depth];
  logic                  done_q     [Depth];
  logic                  reg_en_q   [Depth];
  logic [4:0]            reg_addr_q [Depth];
  logic [31:0]           data_q     [Depth];
  logic [EXC_WIDTH-1:0]  exc_q      [Depth];
  logic                  ds_q       [Depth];
  logic [31:0]           pc_q       [Depth];

  logic [ADDR_WIDTH-1:0] head_q, tail_q;
  logic [ADDR_WIDTH:0]   count_q;

  logic do_write, do_result, do_commit;

  assign can_write  = (count_q != FullCount);
  assign can_commit = valid_q[head_q] && done_q[head_q];
  assign write_addr = tail_q;

  assign do_write  = write_en && can_write;
  assign do_result = result_en && valid_q[result_addr];
  assign do_commit = commit_en && can_commit;

  assign commit_reg_write_en   = reg_en_q[head_q];
  assign commit_reg_write_addr = reg_addr_q[head_q];
  assign commit_reg_write_data = data_q[head_q];
  assign commit_exception_type = exc_q[head_q];
  assign commit_is_delayslot   = ds_q[head_q];
  assign commit_pc             = pc_q[head_q];

  always_comb begin
    read_ready_1 = valid_q[read_addr_1] && done_q[read_addr_1];
    read_data_1  = data_q[read_addr_1];
    read_ready_2 = valid_q[read_addr_2] && done_q[read_addr_2];
    read_data_2  = data_q[read_addr_2];
`ifdef ROB_RESULT_BYPASS_EN
    if (do_result && (result_addr == read_addr_1)) begin
      read_ready_1 = 1'b1;
      read_data_1  = result_data;
    end
    if (do_result && (result_addr == read_addr_2)) begin
      read_ready_2 = 1'b1;
      read_data_2  = result_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        valid_q[i]    <= 1'b0;
        done_q[i]     <= 1'b0;
        reg_en_q[i]   <= 1'b0;
        reg_addr_q[i] <= '0;
        data_q[i]     <= '0;
        exc_q[i]      <= '0;
        ds_q[i]       <= 1'b0;
        pc_q[i]       <= '0;
      end
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < Depth; i++) begin
        valid_q[i] <= 1'b0;
        done_q[i]  <= 1'b0;
      end
    end else begin
      if (do_write) begin
        valid_q[tail_q]    <= 1'b1;
        // A pre-issue exception means the entry never executes, so it is complete now.
        done_q[tail_q]     <= |write_exception_type;
        reg_en_q[tail_q]   <= write_reg_write_en;
        reg_addr_q[tail_q] <= write_reg_write_addr;
        data_q[tail_q]     <= '0;
        exc_q[tail_q]      <= write_exception_type;
        ds_q[tail_q]       <= write_is_delayslot;
        pc_q[tail_q]       <= write_pc;
        tail_q             <= tail_q + ADDR_WIDTH'(1);
      end
      if (do_result) begin
        data_q[result_addr] <= result_data;
        done_q[result_addr] <= 1'b1;
        if ((exc_q[result_addr] == '0) && (result_exception_type != '0)) begin
          exc_q[result_addr] <= result_exception_type;
        end
      end
      // Placed after the result update so a retiring head is always cleared.
      if (do_commit) begin
        valid_q[head_q] <= 1'b0;
        done_q[head_q]  <= 1'b0;
        head_q          <= head_q + ADDR_WIDTH'(1);
      end
      case ({do_write, do_commit})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: commit scoreboard plus point checks of the other ports.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        write_en;
  logic        can_write;
  logic [3:0]  write_addr;
  logic        write_reg_write_en;
  logic [4:0]  write_reg_write_addr;
  logic [3:0]  write_exception_type;
  logic        write_is_delayslot;
  logic [31:0] write_pc;
  logic        result_en;
  logic [3:0]  result_addr;
  logic [31:0] result_data;
  logic [3:0]  result_exception_type;
  logic        commit_en;
  logic        can_commit;
  logic        commit_reg_write_en;
  logic [4:0]  commit_reg_write_addr;
  logic [31:0] commit_reg_write_data;
  logic [3:0]  commit_exception_type;
  logic        commit_is_delayslot;
  logic [31:0] commit_pc;
  logic [3:0]  read_addr_1, read_addr_2;
  logic        read_ready_1, read_ready_2;
  logic [31:0] read_data_1, read_data_2;

  typedef struct packed {
    logic        reg_en;
    logic [4:0]  reg_addr;
    logic [31:0] data;
    logic [3:0]  exc;
    logic        ds;
    logic [31:0] pc;
  } commit_t;

  commit_t exp_q[$];
  int total = 0;
  int bad   = 0;

  reorder_buffer #(.ADDR_WIDTH(4), .EXC_WIDTH(4)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .flush                 (flush),
    .write_en              (write_en),
    .can_write             (can_write),
    .write_addr            (write_addr),
    .write_reg_write_en    (write_reg_write_en),
    .write_reg_write_addr  (write_reg_write_addr),
    .write_exception_type  (write_exception_type),
    .write_is_delayslot    (write_is_delayslot),
    .write_pc              (write_pc),
    .result_en             (result_en),
    .result_addr           (result_addr),
    .result_data           (result_data),
    .result_exception_type (result_exception_type),
    .commit_en             (commit_en),
    .can_commit            (can_commit),
    .commit_reg_write_en   (commit_reg_write_en),
    .commit_reg_write_addr (commit_reg_write_addr),
    .commit_reg_write_data (commit_reg_write_data),
    .commit_exception_type (commit_exception_type),
    .commit_is_delayslot   (commit_is_delayslot),
    .commit_pc             (commit_pc),
    .read_addr_1           (read_addr_1),
    .read_addr_2           (read_addr_2),
    .read_ready_1          (read_ready_1),
    .read_ready_2          (read_ready_2),
    .read_data_1           (read_data_1),
    .read_data_2           (read_data_2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(input logic en, input logic [4:0] ra, input logic [3:0] exc,
                           input logic ds, input logic [31:0] pc);
    write_en             = 1'b1;
    write_reg_write_en   = en;
    write_reg_write_addr = ra;
    write_exception_type = exc;
    write_is_delayslot   = ds;
    write_pc             = pc;
  endtask

  task automatic set_result(input logic [3:0] id, input logic [31:0] d, input logic [3:0] exc);
    result_en             = 1'b1;
    result_addr           = id;
    result_data           = d;
    result_exception_type = exc;
  endtask

  // A commit handshake seen here retires at the next rising edge.
  always @(negedge clk) begin
    if (!rst && !flush && commit_en && can_commit) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_commit", 32'd1, 32'd0);
      end else begin
        commit_t e;
        e = exp_q.pop_front();
        chk("commit_reg_en",   32'(commit_reg_write_en),   32'(e.reg_en));
        chk("commit_reg_addr", 32'(commit_reg_write_addr), 32'(e.reg_addr));
        chk("commit_data",     commit_reg_write_data,      e.data);
        chk("commit_exc",      32'(commit_exception_type), 32'(e.exc));
        chk("commit_ds",       32'(commit_is_delayslot),   32'(e.ds));
        chk("commit_pc",       commit_pc,                  e.pc);
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; write_en = 1'b0; commit_en = 1'b0; result_en = 1'b0;
    write_reg_write_en = 1'b0; write_reg_write_addr = '0; write_exception_type = '0;
    write_is_delayslot = 1'b0; write_pc = '0; result_addr = '0; result_data = '0;
    result_exception_type = '0; read_addr_1 = '0; read_addr_2 = '0;
    step(); step();
    rst = 1'b0;
    #1;
    chk("rst_can_write", 32'(can_write), 32'd1);
    chk("rst_can_commit", 32'(can_commit), 32'd0);
    chk("rst_write_addr", 32'(write_addr), 32'd0);
    chk("rst_commit_pc", commit_pc, 32'd0);
    chk("rst_read_ready_1", 32'(read_ready_1), 32'd0);
    chk("rst_read_data_1", read_data_1, 32'd0);

    // Fill all 16 entries, then try a 17th.
    for (int i = 0; i < 16; i++) begin
      chk("fill_write_addr", 32'(write_addr), 32'(i));
      set_write(1'b1, 5'(i + 1), 4'd0, 1'b0, 32'h1000 + 32'(4 * i));
      step();
    end
    chk("full_can_write", 32'(can_write), 32'd0);
    chk("full_write_addr", 32'(write_addr), 32'd0);
    step();
    write_en = 1'b0;
    chk("full17_can_write", 32'(can_write), 32'd0);
    chk("full17_write_addr", 32'(write_addr), 32'd0);

    // Full: commit and refused write in the same cycle.
    set_result(4'd0, 32'h100, 4'd0);
    step();
    result_en = 1'b0;
    chk("full_head_done", 32'(can_commit), 32'd1);
    exp_q.push_back('{1'b1, 5'd1, 32'h100, 4'd0, 1'b0, 32'h1000});
    set_write(1'b1, 5'd30, 4'd0, 1'b0, 32'hDEAD0000);
    commit_en = 1'b1;
    step();
    write_en = 1'b0; commit_en = 1'b0;
    chk("fullc_can_write", 32'(can_write), 32'd1);
    chk("fullc_write_addr", 32'(write_addr), 32'd0);
    chk("fullc_can_commit", 32'(can_commit), 32'd0);
    chk("fullc_head_pc", commit_pc, 32'h1004);

    // Reset in the middle of operation.
    rst = 1'b1;
    #2;
    chk("midrst_can_write", 32'(can_write), 32'd1);
    chk("midrst_write_addr", 32'(write_addr), 32'd0);
    step();
    rst = 1'b0;
    read_addr_1 = 4'd3;
    #1;
    chk("midrst_can_commit", 32'(can_commit), 32'd0);
    chk("midrst_read_ready", 32'(read_ready_1), 32'd0);
    chk("midrst_commit_pc", commit_pc, 32'd0);

    // Single write, result, commit.
    set_write(1'b1, 5'd5, 4'd0, 1'b0, 32'hBFC00000);
    step();
    write_en = 1'b0;
    chk("w0_can_commit", 32'(can_commit), 32'd0);
    set_result(4'd0, 32'h1234, 4'd0);
    step();
    result_en = 1'b0;
    chk("r0_can_commit", 32'(can_commit), 32'd1);
    chk("r0_data", commit_reg_write_data, 32'h1234);
    chk("r0_pc", commit_pc, 32'hBFC00000);
    exp_q.push_back('{1'b1, 5'd5, 32'h1234, 4'd0, 1'b0, 32'hBFC00000});
    commit_en = 1'b1;
    step();
    commit_en = 1'b0;
    chk("c0_can_commit", 32'(can_commit), 32'd0);
    chk("c0_write_addr", 32'(write_addr), 32'd1);

    // Pre-issue exception: done without a result; first exception wins.
    set_write(1'b0, 5'd0, 4'd3, 1'b1, 32'h2000);
    step();
    write_en = 1'b0;
    chk("exc_can_commit", 32'(can_commit), 32'd1);
    set_result(4'd1, 32'h55, 4'd5);
    step();
    result_en = 1'b0;
    chk("exc_kept", 32'(commit_exception_type), 32'd3);
    chk("exc_data", commit_reg_write_data, 32'h55);
    exp_q.push_back('{1'b0, 5'd0, 32'h55, 4'd3, 1'b1, 32'h2000});
    commit_en = 1'b1;
    step();
    commit_en = 1'b0;
    chk("exc_after_commit", 32'(can_commit), 32'd0);

    // Read port timing for a result (bypass dependent).
    set_write(1'b1, 5'd7, 4'd0, 1'b0, 32'h3000);
    step();
    write_en = 1'b0;
    read_addr_1 = 4'd2;
    read_addr_2 = 4'd1;
    set_result(4'd2, 32'hAA, 4'd0);
    #1;
`ifdef ROB_RESULT_BYPASS_EN
    chk("byp_ready_same", 32'(read_ready_1), 32'd1);
    chk("byp_data_same", read_data_1, 32'hAA);
`else
    chk("nobyp_ready_same", 32'(read_ready_1), 32'd0);
    chk("nobyp_data_same", read_data_1, 32'd0);
`endif
    chk("retired_ready_2", 32'(read_ready_2), 32'd0);
    step();
    result_en = 1'b0;
    chk("rd_ready_next", 32'(read_ready_1), 32'd1);
    chk("rd_data_next", read_data_1, 32'hAA);
    exp_q.push_back('{1'b1, 5'd7, 32'hAA, 4'd0, 1'b0, 32'h3000});
    commit_en = 1'b1;
    step();
    commit_en = 1'b0;

    // Flush wins over result and commit in the same cycle.
    for (int i = 0; i < 5; i++) begin
      set_write(1'b1, 5'(i + 10), 4'd0, 1'b0, 32'h4000 + 32'(4 * i));
      step();
    end
    write_en = 1'b0;
    set_result(4'd3, 32'h33, 4'd0);
    step();
    result_en = 1'b0;
    chk("pre_flush_can_commit", 32'(can_commit), 32'd1);
    flush = 1'b1;
    commit_en = 1'b1;
    set_result(4'd4, 32'h44, 4'd0);
    step();
    flush = 1'b0; commit_en = 1'b0; result_en = 1'b0;
    read_addr_1 = 4'd4;
    read_addr_2 = 4'd3;
    #1;
    chk("flush_can_write", 32'(can_write), 32'd1);
    chk("flush_write_addr", 32'(write_addr), 32'd0);
    chk("flush_can_commit", 32'(can_commit), 32'd0);
    chk("flush_ready_1", 32'(read_ready_1), 32'd0);
    chk("flush_ready_2", 32'(read_ready_2), 32'd0);

    // Normal operation resumes from id 0 after the flush.
    set_write(1'b1, 5'd9, 4'd0, 1'b0, 32'h5000);
    step();
    write_en = 1'b0;
    chk("pf_write_addr", 32'(write_addr), 32'd1);
    chk("pf_can_commit", 32'(can_commit), 32'd0);
    set_result(4'd0, 32'h77, 4'd0);
    step();
    result_en = 1'b0;
    exp_q.push_back('{1'b1, 5'd9, 32'h77, 4'd0, 1'b0, 32'h5000});
    commit_en = 1'b1;
    step();
    commit_en = 1'b0;
    step();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder-buffer storage that sits between the ROB stage, the execution/result bus and the II stage.
- Allocates entries in program order at the tail for the ROB stage write channel.
- Marks entries done as results arrive from execution.
- Presents the head entry on the commit channel for in-order retirement.
- Provides two lookup ports so the II stage can resolve operand references by ROB id.

Parameters:
ADDR_WIDTH, 4, ROB id width; DEPTH = 2**ADDR_WIDTH entries (matches ROB_ADDR_BUS)
EXC_WIDTH, 4, exception type width (matches EXC_TYPE_BUS); EXC_TYPE_NULL encoded as all-zero

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous flush of all entries (pipeline controller)
write_en  input  1  allocate one entry at tail this cycle
can_write  output  1  buffer not full
write_addr  output  ADDR_WIDTH  ROB id of current tail (id of next allocation)
write_reg_write_en  input  1  entry writes a GPR on commit
write_reg_write_addr  input  5  destination GPR
write_exception_type  input  EXC_WIDTH  exception raised before issue
write_is_delayslot  input  1  entry is in a delay slot
write_pc  input  32  instruction PC
result_en  input  1  execution result valid
result_addr  input  ADDR_WIDTH  ROB id of result
result_data  input  32  result value
result_exception_type  input  EXC_WIDTH  exception raised in execution
commit_en  input  1  retire head entry
can_commit  output  1  head valid and done
commit_reg_write_en  output  1  head field
commit_reg_write_addr  output  5  head field
commit_reg_write_data  output  32  head field
commit_exception_type  output  EXC_WIDTH  head field
commit_is_delayslot  output  1  head field
commit_pc  output  32  head field
read_addr_1, read_addr_2  input  ADDR_WIDTH each  operand reference ids
read_ready_1, read_ready_2  output  1 each  referenced entry valid and done
read_data_1, read_data_2  output  32 each  referenced entry data

Behaviour:
Storage and pointers
- Per entry: valid, done, reg_write_en, reg_write_addr, data, exception_type, is_delayslot, pc.
- head/tail are ADDR_WIDTH bits and wrap DEPTH-1 -> 0.
- count is ADDR_WIDTH+1 bits, range 0..DEPTH.

Reset
- Asynchronous on rst: head = tail = count = 0; every entry field = 0.
- Resulting outputs: can_write = 1, can_commit = 0, write_addr = 0, all commit_* = 0, read_ready_* = 0, read_data_* = 0.
- Reset mid-operation discards all entries.

Combinational outputs
- can_write = (count != DEPTH).
- can_commit = valid[head] && done[head].
- write_addr = tail.
- commit_* reflect entry[head]; read_* reflect entry[read_addr_n].

Allocate (write_en && can_write)
- entry[tail] loads all write_* fields; valid = 1; data = 0.
- done = (write_exception_type != 0): an entry with a pre-issue exception never executes.
- tail++.
- write_en while full is ignored: no state change, tail held.

Result (result_en && valid[result_addr])
- data = result_data; done = 1.
- exception_type replaced by result_exception_type only if the stored value is 0 and the result value is non-zero. The first exception wins.
- A result to an invalid entry is ignored, including the entry being allocated in the same cycle.

Commit (commit_en && can_commit)
- valid[head] = 0, done[head] = 0; head++.
- commit_en while !can_commit is ignored.

Simultaneous events
- Allocate and commit in the same cycle: count unchanged; both take effect.
- When full, allocate is refused even if a commit occurs that cycle (can_write uses pre-edge count).
- Write into an empty buffer: can_commit stays 0 until the following cycle at the earliest.

Flush
- Synchronous; priority over allocate/result/commit in the same cycle.
- head = tail = count = 0; all valid and done cleared; other fields retained.

Latency
- Allocation is visible on commit/read ports 1 cycle after the write edge.
- A result is visible 1 cycle after its edge (0 cycles on read ports with the optional feature).

Optional Feature:
ROB_RESULT_BYPASS_EN
- Defined: if result_en && valid[result_addr] && result_addr == read_addr_n, then read_ready_n = 1 and read_data_n = result_data in the same cycle.
- Not defined: read ports reflect registered state only; ready appears 1 cycle after the result.
- The commit port is never bypassed in either mode.

Test Plan:
- Reset then 16 consecutive writes with no commit -> write_addr steps 0..15, can_write = 0 after 16th; a 17th write_en leaves tail at 0 and count at 16.
- Write id 0 (pc 0xBFC00000, reg 5), result id 0 data 0x1234 -> next cycle can_commit = 1, commit_reg_write_data = 0x1234, commit_pc = 0xBFC00000; commit_en -> can_commit = 0, head = 1.
- Full buffer, head done, write_en and commit_en in the same cycle -> commit occurs, write refused, count 15, can_write = 1 next cycle.
- Write with write_exception_type = 3 -> can_commit = 1 the next cycle with no result; later result_exception_type 5 to the same id -> commit_exception_type stays 3.
- Fill 5 entries, flush asserted together with result_en and commit_en -> next cycle count 0, write_addr 0, can_commit 0, read_ready_* 0.
- read_addr_1 = 2 with result_en to id 2, data 0xAA -> same cycle read_ready_1 = 1 and read_data_1 = 0xAA with ROB_RESULT_BYPASS_EN; without it, 0 that cycle and 1/0xAA next cycle.
